// File: rtl/regset_xfer_ctrl.sv
// regset_xfer_ctrl: queued transfer sequencer for the two-register set and its
// shared 8-bit bus. A DEPTH-entry command FIFO feeds an IDLE/SETUP/WRITE/RELEASE
// strobe sequencer that drives the active-low NOE/NWE controls. The settle and
// turnaround phases keep two bus drivers from ever overlapping.
// Optional build macro: REGSET_XFER_BUS_CHECK_EN adds a sticky bus-contention
// monitor on i_busNOE; without it o_busError is tied low and i_busNOE is ignored.

module regset_xfer_ctrl #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,

    // command push interface
    input  logic       i_cmdValid,
    output logic       o_cmdReady,
    input  logic [1:0] i_cmdSrc,
    input  logic [1:0] i_cmdDst,
    input  logic [7:0] i_cmdImm,
    input  logic       i_cmdAluSel,

    // register-set controls
    output logic       o_ctrlReg0BusNOE,
    output logic       o_ctrlReg1BusNOE,
    output logic [7:0] o_imm,
    output logic       o_immNOE,
    output logic       o_ctrlReg0NWE,
    output logic       o_ctrlReg1NWE,
    output logic       o_ctrlAluSel,
    output logic       o_busy,

    // bus monitor
    input  logic       i_busNOE,
    output logic       o_busError
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = 4;
    localparam int unsigned ENT_W = 13;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);

    // Source encodings
    localparam logic [1:0] SRC_R0  = 2'd0;
    localparam logic [1:0] SRC_R1  = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;
    localparam logic [1:0] SRC_NOP = 2'd3;

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    // FIFO entry layout: {alu_sel, imm[7:0], dst[1:0], src[1:0]}
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;
    logic [1:0]       head_src;
    logic [1:0]       head_dst;
    logic [7:0]       head_imm;
    logic             head_alu;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push;
    logic             pop;

    logic [1:0]       state_q, state_d;
    logic [SET_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       src_q,   src_d;
    logic [1:0]       dst_q,   dst_d;
    logic [7:0]       imm_q,   imm_d;
    logic             alu_q,   alu_d;

    logic             drive_d;
    logic             ready_q,   ready_d;
    logic             busy_q,    busy_d;
    logic             noe0_q,    noe0_d;
    logic             noe1_q,    noe1_d;
    logic             imm_noe_q, imm_noe_d;
    logic             nwe0_q,    nwe0_d;
    logic             nwe1_q,    nwe1_d;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign push     = i_cmdValid && ready_q;
    assign head     = mem_q[rd_ptr_q];
    assign head_src = head[1:0];
    assign head_dst = head[3:2];
    assign head_imm = head[11:4];
    assign head_alu = head[12];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_cmdAluSel, i_cmdImm, i_cmdDst, i_cmdSrc};
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO pointer/occupancy registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    // Next-state: pop in IDLE, hold the source for SETTLE_CYCLES, strobe once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    alu_d = head_alu;
                    // Empty destination or reserved source retire as NOPs
                    if ((head_dst != 2'd0) && (head_src != SRC_NOP)) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETTLE_LD;
                        src_d   = head_src;
                        dst_d   = head_dst;
                        if (head_src == SRC_IMM) begin
                            imm_d = head_imm;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q <= SET_W'(1)) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - SET_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and latched command
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_R0;
            dst_q   <= 2'd0;
            imm_q   <= 8'd0;
            alu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered strobes and status
    // ------------------------------------------------------------------
    // Decode from the next state so every strobe leaves a flop edge-aligned
    always_comb begin
        drive_d   = (state_d == ST_SETUP) || (state_d == ST_WRITE);
        noe0_d    = ~(drive_d && (src_d == SRC_R0));
        noe1_d    = ~(drive_d && (src_d == SRC_R1));
        imm_noe_d = ~(drive_d && (src_d == SRC_IMM));
        nwe0_d    = ~((state_d == ST_WRITE) && dst_d[0]);
        nwe1_d    = ~((state_d == ST_WRITE) && dst_d[1]);
        busy_d    = (state_d != ST_IDLE) || (count_d != '0);
        ready_d   = (count_d != FULL_CNT);
    end

    // Output flops; reset releases the bus and cancels any pending strobe
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            noe0_q    <= 1'b1;
            noe1_q    <= 1'b1;
            imm_noe_q <= 1'b1;
            nwe0_q    <= 1'b1;
            nwe1_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            noe0_q    <= noe0_d;
            noe1_q    <= noe1_d;
            imm_noe_q <= imm_noe_d;
            nwe0_q    <= nwe0_d;
            nwe1_q    <= nwe1_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign o_cmdReady       = ready_q;
    assign o_ctrlReg0BusNOE = noe0_q;
    assign o_ctrlReg1BusNOE = noe1_q;
    assign o_immNOE         = imm_noe_q;
    assign o_imm            = imm_q;
    assign o_ctrlReg0NWE    = nwe0_q;
    assign o_ctrlReg1NWE    = nwe1_q;
    assign o_ctrlAluSel     = alu_q;
    assign o_busy           = busy_q;

    // ------------------------------------------------------------------
    // Bus contention monitor
    // ------------------------------------------------------------------
`ifdef REGSET_XFER_BUS_CHECK_EN
    logic bus_err_q, bus_err_d;

    // Flag a driver while the bus should be quiet, or a missing register driver in WRITE
    always_comb begin
        bus_err_d = bus_err_q;
        if (((state_q == ST_IDLE) || (state_q == ST_RELEASE)) && !i_busNOE) begin
            bus_err_d = 1'b1;
        end
        if ((state_q == ST_WRITE) && !src_q[1] && i_busNOE) begin
            bus_err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign o_busError = bus_err_q;
`else
    logic unused_bus_noe;

    assign unused_bus_noe = i_busNOE;
    assign o_busError     = 1'b0;
`endif

endmodule

// File: tb/tb_regset_xfer_ctrl.sv
// tb_regset_xfer_ctrl: directed bench for regset_xfer_ctrl with a transaction-level
// reference model, an emulated two-register set on the shared bus, and a per-cycle
// output comparison plus hand-computed literal expectations.

module tb_regset_xfer_ctrl;

    localparam int DEPTH = 4;
    localparam int S     = 1;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] dst;
        logic [7:0] imm;
        logic       alu;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic [7:0] cmd_imm;
    logic       cmd_alu;
    logic       noe0, noe1, immnoe, nwe0, nwe1, alusel, busy, bus_err;
    logic [7:0] imm;
    logic       force_bus_low;
    logic       bus_noe;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    cmd_t mq[$];
    bit   m_active = 1'b0;
    int   m_t      = 0;
    cmd_t m_cur    = '0;
    logic m_alu    = 1'b0;
    logic m_err    = 1'b0;
    logic bus_smp  = 1'b1;

    // Emulated register set and its write log {reg index, value}
    logic [7:0]  r0 = 8'h00;
    logic [7:0]  r1 = 8'h00;
    logic [15:0] wlog[$];

    assign bus_noe = force_bus_low ? 1'b0 : (noe0 & noe1);

    regset_xfer_ctrl #(.DEPTH(DEPTH), .SETTLE_CYCLES(S)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_cmdValid       (cmd_valid),
        .o_cmdReady       (cmd_ready),
        .i_cmdSrc         (cmd_src),
        .i_cmdDst         (cmd_dst),
        .i_cmdImm         (cmd_imm),
        .i_cmdAluSel      (cmd_alu),
        .o_ctrlReg0BusNOE (noe0),
        .o_ctrlReg1BusNOE (noe1),
        .o_imm            (imm),
        .o_immNOE         (immnoe),
        .o_ctrlReg0NWE    (nwe0),
        .o_ctrlReg1NWE    (nwe1),
        .o_ctrlAluSel     (alusel),
        .o_busy           (busy),
        .i_busNOE         (bus_noe),
        .o_busError       (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [1:0] d, input logic [7:0] im, input logic a);
        cmd_src   = s;
        cmd_dst   = d;
        cmd_imm   = im;
        cmd_alu   = a;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && (n < 60)) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    // Bus sample just before each rising edge, when all bench drives are stable
    initial begin : bus_sampler
        forever begin
            @(negedge clk);
            #4;
            bus_smp = bus_noe;
        end
    end

    // Reference model: a popped command occupies S+2 cycles after its pop edge
    // (S settle, 1 write, 1 turnaround); the next pop needs one idle cycle.
    initial begin : model
        cmd_t tmp;
        int   pre_size;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_active = 1'b0;
                m_t      = 0;
                m_alu    = 1'b0;
                m_err    = 1'b0;
            end else begin
                pre_size = mq.size();
`ifdef REGSET_XFER_BUS_CHECK_EN
                if ((!m_active || (m_t == S + 1)) && !bus_smp) m_err = 1'b1;
                if (m_active && (m_t == S) && (m_cur.src != 2'd2) && bus_smp) m_err = 1'b1;
`endif
                if (m_active) begin
                    m_t++;
                    if (m_t > S + 1) m_active = 1'b0;
                end else if (pre_size > 0) begin
                    tmp   = mq.pop_front();
                    m_alu = tmp.alu;
                    if ((tmp.dst != 2'd0) && (tmp.src != 2'd3)) begin
                        m_active = 1'b1;
                        m_cur    = tmp;
                        m_t      = 0;
                    end
                end
                if (cmd_valid && (pre_size < DEPTH)) begin
                    mq.push_back({cmd_src, cmd_dst, cmd_imm, cmd_alu});
                end
            end
        end
    end

    // Per-cycle comparison against the model, then the register set reacts to the strobes
    initial begin : compare
        logic       e_drive;
        logic [7:0] busval;
        forever begin
            @(negedge clk);
            e_drive = m_active && (m_t <= S);
            chk("noe0",   32'(noe0),      32'(!(e_drive && (m_cur.src == 2'd0))));
            chk("noe1",   32'(noe1),      32'(!(e_drive && (m_cur.src == 2'd1))));
            chk("immnoe", 32'(immnoe),    32'(!(e_drive && (m_cur.src == 2'd2))));
            chk("nwe0",   32'(nwe0),      32'(!(m_active && (m_t == S) && m_cur.dst[0])));
            chk("nwe1",   32'(nwe1),      32'(!(m_active && (m_t == S) && m_cur.dst[1])));
            chk("busy",   32'(busy),      32'(m_active || (mq.size() > 0)));
            chk("ready",  32'(cmd_ready), 32'(mq.size() < DEPTH));
            chk("alusel", 32'(alusel),    32'(m_alu));
            chk("buserr", 32'(bus_err),   32'(m_err));
            if (!immnoe) chk("imm_value", 32'(imm), 32'(m_cur.imm));
            chk("one_driver", 32'((32'(!noe0) + 32'(!noe1) + 32'(!immnoe)) <= 32'd1), 32'd1);
            chk("nwe_needs_noe", 32'((!nwe0 || !nwe1) && noe0 && noe1 && immnoe), 32'd0);

            busval = !noe0 ? r0 : (!noe1 ? r1 : imm);
            if (!nwe0) begin
                r0 = busval;
                wlog.push_back({8'h00, busval});
            end
            if (!nwe1) begin
                r1 = busval;
                wlog.push_back({8'h01, busval});
            end
        end
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int          lo_cnt, first_lo, nwe_at, first_r1;
        int          acc;
        logic        rdy5;
        logic [7:0]  imm_seen;
        logic [1:0]  t4_src [5];
        logic [1:0]  t4_dst [5];
        logic [7:0]  t4_imm [5];
        logic [15:0] exp_log [5];

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_src = 2'd0;
        cmd_dst = 2'd0;
        cmd_imm = 8'h00;
        cmd_alu = 1'b0;
        force_bus_low = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_strobes", 32'({noe0, noe1, immnoe, nwe0, nwe1}), 32'h1f);
        chk("rst_imm",     32'(imm), 32'h00);
        chk("rst_alusel",  32'(alusel), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_buserr",  32'(bus_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready",   32'(cmd_ready), 32'd1);

        // Immediate 0xA5 to R0: two drive cycles, write in the second
        push(2'd2, 2'd1, 8'hA5, 1'b0);
        lo_cnt = 0; first_lo = -1; nwe_at = -1; imm_seen = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (!immnoe) begin
                lo_cnt++;
                if (first_lo < 0) begin
                    first_lo = i;
                    imm_seen = imm;
                end
            end
            if (!nwe0) nwe_at = i;
            tick();
        end
        chk("t2_immnoe_cycles", 32'(lo_cnt), 32'd2);
        chk("t2_immnoe_start",  32'(first_lo), 32'd1);
        chk("t2_nwe0_cycle",    32'(nwe_at), 32'd2);
        chk("t2_imm_bus",       32'(imm_seen), 32'hA5);
        chk("t2_r0",            32'(r0), 32'hA5);
        chk("t2_busy_done",     32'(busy), 32'd0);

        // Reset during SETUP of R1->R0 aborts with no write
        wlog.delete();
        push(2'd1, 2'd1, 8'h00, 1'b0);
        chk("t1_noe1_before_pop", 32'(noe1), 32'd1);
        tick();
        chk("t1_noe1_setup", 32'(noe1), 32'd0);
        rst = 1'b1;
        #1;
        chk("t1_rst_strobes", 32'({noe0, noe1, immnoe, nwe0, nwe1}), 32'h1f);
        chk("t1_rst_busy",    32'(busy), 32'd0);
        chk("t1_rst_ready",   32'(cmd_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t1_r0_kept",  32'(r0), 32'hA5);
        chk("t1_no_write", 32'(wlog.size()), 32'd0);

        // Imm 0x3C to R1, then R1 to R0 back to back
        push(2'd2, 2'd2, 8'h3C, 1'b0);
        push(2'd1, 2'd1, 8'h00, 1'b0);
        first_lo = -1; first_r1 = -1;
        for (int j = 0; j < 12; j++) begin
            if (!immnoe && (first_lo < 0)) first_lo = j;
            if (!noe1 && (first_r1 < 0)) first_r1 = j;
            tick();
        end
        chk("t3_imm_start", 32'(first_lo), 32'd0);
        chk("t3_gap",       32'(first_r1 - first_lo), 32'd4);
        chk("t3_r0",        32'(r0), 32'h3C);
        chk("t3_r1",        32'(r1), 32'h3C);
        wait_idle("t3_idle");

        // Fill the FIFO while busy; the fifth offer is refused
        t4_src = '{2'd2, 2'd0, 2'd2, 2'd1, 2'd2};
        t4_dst = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
        t4_imm = '{8'h22, 8'h00, 8'h33, 8'h00, 8'h55};
        exp_log = '{16'h0011, 16'h0122, 16'h0111, 16'h0033, 16'h0011};
        wlog.delete();
        push(2'd2, 2'd1, 8'h11, 1'b0);
        acc = 0;
        rdy5 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_src = t4_src[k];
            cmd_dst = t4_dst[k];
            cmd_imm = t4_imm[k];
            cmd_alu = 1'b0;
            cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            if (k == 4) rdy5 = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("t4_accepted",   32'(acc), 32'd4);
        chk("t4_full_ready", 32'(rdy5), 32'd0);
        wait_idle("t4_idle");
        chk("t4_ready_again", 32'(cmd_ready), 32'd1);
        chk("t4_log_size",    32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) chk($sformatf("t4_log%0d", k), 32'(wlog[k]), 32'(exp_log[k]));
        end
        chk("t4_r0", 32'(r0), 32'h11);
        chk("t4_r1", 32'(r1), 32'h11);

        // dst=0 with aluSel=1: no strobe, select updates at the pop edge
        push(2'd0, 2'd0, 8'h00, 1'b1);
        chk("t5_alu_before", 32'(alusel), 32'd0);
        tick();
        chk("t5_alu_after",  32'(alusel), 32'd1);
        chk("t5_strobes",    32'({noe0, noe1, immnoe, nwe0, nwe1}), 32'h1f);
        chk("t5_busy",       32'(busy), 32'd0);
        tick();
        chk("t5_alu_hold",   32'(alusel), 32'd1);

        // Foreign driver on the bus while IDLE
        force_bus_low = 1'b1;
        tick();
        force_bus_low = 1'b0;
`ifdef REGSET_XFER_BUS_CHECK_EN
        chk("t6_err_set", 32'(bus_err), 32'd1);
        tick();
        tick();
        tick();
        chk("t6_err_sticky", 32'(bus_err), 32'd1);
`else
        chk("t6_err_off", 32'(bus_err), 32'd0);
        tick();
        tick();
`endif
        rst = 1'b1;
        #1;
        chk("t6_err_cleared", 32'(bus_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_ready", 32'(cmd_ready), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regset_xfer_ctrl.md
Name: regset_xfer_ctrl

Overview:
- Sequencer for the two-register set and its shared 8-bit bus.
- Accepts queued transfer commands (R0, R1 or an immediate to R0 and/or R1) over a valid/ready handshake.
- Generates the active-low bus-drive (NOE) and write (NWE) strobes with a settle phase and a turnaround phase, so two drivers never overlap.
- Also holds the register set's ALU-operand select.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- SETTLE_CYCLES, 1, cycles the source drives the bus before the write strobe; range 1..15.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmdValid  in  1  command offered.
- o_cmdReady  out  1  FIFO not full; a push occurs when valid and ready are both high at a rising edge.
- i_cmdSrc  in  2  0=R0, 1=R1, 2=immediate, 3=reserved (NOP).
- i_cmdDst  in  2  bit0 writes R0, bit1 writes R1; 0 = NOP.
- i_cmdImm  in  8  immediate value, used when src=2.
- i_cmdAluSel  in  1  new ALU operand select, applied when the command is popped.
- o_ctrlReg0BusNOE  out  1  low = R0 drives the bus.
- o_ctrlReg1BusNOE  out  1  low = R1 drives the bus.
- o_imm  out  8  immediate bus value, registered.
- o_immNOE  out  1  low = o_imm drives the bus.
- o_ctrlReg0NWE  out  1  low = R0 loads from the bus at the next rising edge.
- o_ctrlReg1NWE  out  1  low = R1 loads from the bus at the next rising edge.
- o_ctrlAluSel  out  1  ALU operand select.
- o_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- i_busNOE  in  1  combined drive-enable from the register set (low = some register drives); used only by the optional feature.
- o_busError  out  1  sticky contention flag; optional feature only, otherwise tied 0.

Behaviour:
- Reset (async, immediate):
  - FIFO emptied, FSM goes to IDLE.
  - All NOE/NWE outputs = 1, o_imm = 0, o_ctrlAluSel = 0, o_busError = 0.
  - o_cmdReady = 1 after reset deasserts.
  - A reset during a transfer aborts it with no write strobe completed.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count.
  - Push and pop in the same cycle leave the count unchanged.
  - Push is ignored when full; o_cmdReady = 0 when full.
- FSM states: IDLE, SETUP, WRITE, RELEASE.
  - IDLE: all strobes high. If the FIFO is non-empty, pop the head, latch it, and update o_ctrlAluSel from the popped entry.
    - dst=0 or src=3: stay in IDLE; no strobe is asserted.
    - Otherwise go to SETUP and load the settle counter with SETTLE_CYCLES.
  - SETUP: source NOE low (o_imm = immediate when src=2). Decrement the counter; go to WRITE when it reaches 1.
  - WRITE: source NOE still low; NWE low for each set dst bit, for exactly one cycle. Then go to RELEASE.
  - RELEASE: all strobes high for one cycle (bus turnaround). Then go to IDLE.
- Latency: a command pushed at edge N, with an empty FIFO and the FSM in IDLE:
  - popped at edge N+1;
  - source NOE low during cycles N+1 .. N+1+SETTLE_CYCLES;
  - NWE low during cycle N+1+SETTLE_CYCLES;
  - the register updates at edge N+2+SETTLE_CYCLES.
  - Back-to-back throughput: one transfer per SETTLE_CYCLES+3 cycles.
- Invariants:
  - At most one source NOE is low at any time.
  - NWE is never low unless a source NOE is also low.
  - src equal to dst (e.g. R0 to R0) is legal and rewrites the same value.
  - dst=3 writes both registers in the same cycle.

Optional Feature:
- Macro: REGSET_XFER_BUS_CHECK_EN.
- Defined:
  - o_busError is set when i_busNOE is low while the controller is in IDLE or RELEASE, or when i_busNOE is high during WRITE with src in {0,1}.
  - It stays set until reset.
- Undefined: the check logic is absent, i_busNOE is ignored, and o_busError = 0.

Test Plan:
- Reset mid-SETUP (src=1, dst=1) -> all strobes go to 1 immediately; R0 unchanged; o_busy=0; o_cmdReady=1.
- Push {src=2, imm=0xA5, dst=1}, SETTLE_CYCLES=1 -> o_immNOE low for 2 cycles; o_ctrlReg0NWE low in the 2nd of them; R0=0xA5; then RELEASE and IDLE.
- Push imm 0x3C to R1, then {src=1, dst=1} -> R0=0x3C, R1=0x3C; second transfer starts 4 cycles after the first; NOE windows never overlap.
- Push 5 commands with DEPTH=4 while the FSM is busy -> o_cmdReady=0 after the 4th accepted push; all 4 accepted commands execute in order.
- Push {dst=0, aluSel=1} -> no strobe asserted; o_ctrlAluSel=1 one edge after the pop.
- With REGSET_XFER_BUS_CHECK_EN defined, force i_busNOE=0 in IDLE -> o_busError=1 and stays 1 until reset.
